// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath slice: bus width, register count,
// ALU opcode encodings and the C-operand sign-extension helper.
package datapath_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  // ALU opcodes; any encoding not listed here produces a zero result.
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01111;
  localparam logic [4:0] OP_NOT  = 5'b10000;

  // C operand: IR[18:0] sign-extended to the bus width.
  function automatic logic [DATA_W-1:0] sign_ext_c(input logic [18:0] imm);
    return {{(DATA_W-19){imm[18]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control/observation bundle between a control unit (master) and the
// datapath (slave).
//   master -> slave : register load strobes (Rin, HIin, ...), bus source
//                     strobes (Rout, HIout, ...), MDRread, IncPC,
//                     ALU_opcode, Mdatain, and InPort_data when
//                     DATAPATH_INPORT_EN is defined.
//   slave -> master : register contents R[0..15], HI, LO, Y, ZLO, ZHI,
//                     Z_register, plus PC, IR, MAR, MDR for decode/debug.
interface datapath_if;
  import datapath_pkg::*;

  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic HIin, Loin, PCin, MDRin, MARin, IRin, Yin;
  logic Zin, ZHIin, ZLOin;
  logic HIout, Loout, PCout, MDRout, ZHIout, ZLOout, InPortout, Cout, Yout;
  logic ZHighSelect, ZLowSelect;
  logic MDRread, IncPC;
  logic [4:0]        ALU_opcode;
  logic [DATA_W-1:0] Mdatain;
`ifdef DATAPATH_INPORT_EN
  logic [DATA_W-1:0] InPort_data;
`endif

  logic [DATA_W-1:0]   R [NUM_REGS];
  logic [DATA_W-1:0]   HI, LO, Y, ZLO, ZHI;
  logic [2*DATA_W-1:0] Z_register;
  logic [DATA_W-1:0]   PC, IR, MAR, MDR;

  modport master (
`ifdef DATAPATH_INPORT_EN
    output InPort_data,
`endif
    output Rin, Rout, HIin, Loin, PCin, MDRin, MARin, IRin, Yin,
           Zin, ZHIin, ZLOin, HIout, Loout, PCout, MDRout, ZHIout, ZLOout,
           InPortout, Cout, Yout, ZHighSelect, ZLowSelect, MDRread, IncPC,
           ALU_opcode, Mdatain,
    input  R, HI, LO, Y, ZLO, ZHI, Z_register, PC, IR, MAR, MDR
  );

  modport slave (
`ifdef DATAPATH_INPORT_EN
    input  InPort_data,
`endif
    input  Rin, Rout, HIin, Loin, PCin, MDRin, MARin, IRin, Yin,
           Zin, ZHIin, ZLOin, HIout, Loout, PCout, MDRout, ZHIout, ZLOout,
           InPortout, Cout, Yout, ZHighSelect, ZLowSelect, MDRread, IncPC,
           ALU_opcode, Mdatain,
    output R, HI, LO, Y, ZLO, ZHI, Z_register, PC, IR, MAR, MDR
  );

endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU with a 64-bit result.
//   a      : operand A (Y register)
//   b      : operand B (bus)
//   opcode : operation select (datapath_pkg OP_*)
//   result : {high, low}; 32-bit operations leave the high half at zero.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          opcode,
  output logic [2*DATA_W-1:0] result
);

  logic [4:0]                 sh;
  logic [2*DATA_W-1:0]        dbl;
  logic signed [2*DATA_W-1:0] sa, sb;

  assign sh  = b[4:0];
  // Rotates shift a doubled copy and keep the low half; a left rotate by n
  // is a right rotate by 32-n, which also covers n == 0 cleanly.
  assign dbl = {a, a};
  // Sign-extending to 64 bits keeps MUL exact and avoids the 32-bit
  // overflow case of DIV (-2^31 / -1).
  assign sa  = {{DATA_W{a[DATA_W-1]}}, a};
  assign sb  = {{DATA_W{b[DATA_W-1]}}, b};

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // result unassigned (which would infer a latch).
    result = '0;
    case (opcode)
      OP_ADD:  result[DATA_W-1:0] = a + b;
      OP_SUB:  result[DATA_W-1:0] = a - b;
      OP_AND:  result[DATA_W-1:0] = a & b;
      OP_OR:   result[DATA_W-1:0] = a | b;
      OP_SHR:  result[DATA_W-1:0] = a >> sh;
      OP_SHRA: result[DATA_W-1:0] = $signed(a) >>> sh;
      OP_SHL:  result[DATA_W-1:0] = a << sh;
      OP_ROR:  result[DATA_W-1:0] = DATA_W'(dbl >> sh);
      OP_ROL:  result[DATA_W-1:0] = DATA_W'(dbl >> (6'd32 - {1'b0, sh}));
      OP_MUL:  result = sa * sb;
      OP_DIV:  if (b != '0) result = {DATA_W'(sa % sb), DATA_W'(sa / sb)};
      OP_NEG:  result[DATA_W-1:0] = -b;
      OP_NOT:  result[DATA_W-1:0] = ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// 32-bit CPU datapath: 16-entry register file, HI/LO/PC/IR/MAR/MDR/Y/Z,
// one shared combinational bus and a 64-bit-result ALU (A = Y, B = bus).
// Ports:
//   clk : clock, all state updates on the rising edge
//   clr : synchronous active-low clear of every register
//   dp  : datapath_if.slave (strobes in, register contents out)
// Optional feature: define DATAPATH_INPORT_EN to add an InPort register
// sampled every clock from dp.InPort_data; otherwise InPortout drives 0.
module datapath
  import datapath_pkg::*;
(
  input  logic      clk,
  input  logic      clr,
  datapath_if.slave dp
);

  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [DATA_W-1:0]   hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [2*DATA_W-1:0] z_q;
  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   inport_val;
  logic [2*DATA_W-1:0] alu_res;
  logic                zhi_sel, zlo_sel;

  assign zhi_sel = dp.ZHIout | dp.ZHighSelect;
  assign zlo_sel = dp.ZLOout | dp.ZLowSelect;

`ifdef DATAPATH_INPORT_EN
  logic [DATA_W-1:0] inport_q;
  always_ff @(posedge clk) begin
    if (!clr) inport_q <= '0;
    else      inport_q <= dp.InPort_data;
  end
  assign inport_val = inport_q;
`else
  assign inport_val = '0;
`endif

  // Priority bus encoder: the register loop runs high-to-low so the lowest
  // asserted index is the last (winning) assignment.
  always_comb begin
    bus = '0;
    if (|dp.Rout) begin
      for (int i = NUM_REGS - 1; i >= 0; i--)
        if (dp.Rout[i]) bus = rf[i];
    end
    else if (dp.HIout)     bus = hi_q;
    else if (dp.Loout)     bus = lo_q;
    else if (zhi_sel)      bus = z_q[2*DATA_W-1:DATA_W];
    else if (zlo_sel)      bus = z_q[DATA_W-1:0];
    else if (dp.PCout)     bus = pc_q;
    else if (dp.MDRout)    bus = mdr_q;
    else if (dp.InPortout) bus = inport_val;
    else if (dp.Cout)      bus = sign_ext_c(ir_q[18:0]);
    else if (dp.Yout)      bus = y_q;
  end

  datapath_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .opcode (dp.ALU_opcode),
    .result (alu_res)
  );

  // NOTE: the register file is cleared by clr along with the special
  // registers, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end
    else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge bus regardless of statement order.
      for (int i = 0; i < NUM_REGS; i++)
        if (dp.Rin[i]) rf[i] <= bus;
      if (dp.HIin)  hi_q  <= bus;
      if (dp.Loin)  lo_q  <= bus;
      if (dp.IRin)  ir_q  <= bus;
      if (dp.MARin) mar_q <= bus;
      if (dp.Yin)   y_q   <= bus;
      if (dp.MDRin) mdr_q <= dp.MDRread ? dp.Mdatain : bus;

      if (dp.IncPC)     pc_q <= pc_q + 1'b1;
      else if (dp.PCin) pc_q <= bus;

      if (dp.Zin) z_q <= alu_res;
      else begin
        if (dp.ZHIin) z_q[2*DATA_W-1:DATA_W] <= bus;
        if (dp.ZLOin) z_q[DATA_W-1:0]        <= bus;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) dp.R[i] = rf[i];
  end
  assign dp.HI         = hi_q;
  assign dp.LO         = lo_q;
  assign dp.Y          = y_q;
  assign dp.ZLO        = z_q[DATA_W-1:0];
  assign dp.ZHI        = z_q[2*DATA_W-1:DATA_W];
  assign dp.Z_register = z_q;
  assign dp.PC         = pc_q;
  assign dp.IR         = ir_q;
  assign dp.MAR        = mar_q;
  assign dp.MDR        = mdr_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: table-driven ALU vectors, hand-written
// bus/register sequences, and random ALU operations against a model.
module tb_datapath;
  import datapath_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;

  datapath_if dp_if ();

  datapath dut (
    .clk (clk),
    .clr (clr),
    .dp  (dp_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } alu_vec_t;

  alu_vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    dp_if.Rin = '0; dp_if.Rout = '0;
    dp_if.HIin = 0; dp_if.Loin = 0; dp_if.PCin = 0; dp_if.MDRin = 0;
    dp_if.MARin = 0; dp_if.IRin = 0; dp_if.Yin = 0;
    dp_if.Zin = 0; dp_if.ZHIin = 0; dp_if.ZLOin = 0;
    dp_if.HIout = 0; dp_if.Loout = 0; dp_if.PCout = 0; dp_if.MDRout = 0;
    dp_if.ZHIout = 0; dp_if.ZLOout = 0; dp_if.InPortout = 0; dp_if.Cout = 0;
    dp_if.Yout = 0; dp_if.ZHighSelect = 0; dp_if.ZLowSelect = 0;
    dp_if.MDRread = 0; dp_if.IncPC = 0; dp_if.ALU_opcode = '0;
  endtask

  task automatic mdr_load(input logic [31:0] v);
    clear_ctl();
    dp_if.Mdatain = v; dp_if.MDRread = 1; dp_if.MDRin = 1;
    tick();
    clear_ctl();
  endtask

  task automatic set_y(input logic [31:0] v);
    mdr_load(v);
    dp_if.MDRout = 1; dp_if.Yin = 1;
    tick();
    clear_ctl();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    mdr_load(v);
    dp_if.MDRout = 1; dp_if.Rin[idx] = 1;
    tick();
    clear_ctl();
  endtask

  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    set_y(a);
    mdr_load(b);
    dp_if.MDRout = 1; dp_if.ALU_opcode = op; dp_if.Zin = 1;
    tick();
    clear_ctl();
  endtask

  // Reference ALU: plain integer arithmetic on the operation definitions.
  function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned mask = 64'hFFFF_FFFF;
    longint unsigned ua = a, ub = b;
    int              ai = a, bi = b;
    longint          la = ai, lb = bi;
    int unsigned     sh = b % 32;
    longint unsigned p  = 64'd1 << sh;
    longint          q, r;
    logic [31:0]     rot;
    case (op)
      5'd0:  return (ua + ub) & mask;
      5'd1:  return (ua + 64'h1_0000_0000 - ub) & mask;
      5'd2:  return ua & ub;
      5'd3:  return ua | ub;
      5'd4:  return ua / p;
      5'd5: begin
        if (la >= 0) q = la / longint'(p);
        else         q = -((-la + longint'(p) - 1) / longint'(p));
        return q & mask;
      end
      5'd6:  return (ua * p) & mask;
      5'd7: begin
        rot = a;
        repeat (sh) rot = {rot[0], rot[31:1]};
        return {32'd0, rot};
      end
      5'd8: begin
        rot = a;
        repeat (sh) rot = {rot[30:0], rot[31]};
        return {32'd0, rot};
      end
      5'd9:  return la * lb;
      5'd10: begin
        if (b == 0) return 64'd0;
        q = la / lb;
        r = la - q * lb;
        return ((r & mask) << 32) | (q & mask);
      end
      5'd15: return (64'h1_0000_0000 - ub) & mask;
      5'd16: return ub ^ mask;
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    clear_ctl();
    dp_if.Mdatain = '0;
`ifdef DATAPATH_INPORT_EN
    dp_if.InPort_data = 32'h1234_5678;
`endif

    // Reset state
    tick(); tick();
    check("reset Z", dp_if.Z_register, 64'd0);
    check("reset R0", {32'd0, dp_if.R[0]}, 64'd0);
    check("reset PC", {32'd0, dp_if.PC}, 64'd0);
    check("reset MDR", {32'd0, dp_if.MDR}, 64'd0);
    clr = 1;

    // Load path: memory -> MDR -> R0
    mdr_load(32'h0000_000F);
    check("mdr from mem", {32'd0, dp_if.MDR}, 64'hF);
    dp_if.MDRout = 1; dp_if.Rin[0] = 1;
    tick(); clear_ctl();
    check("R0 load", {32'd0, dp_if.R[0]}, 64'hF);

    // ADD Y=4 + R0, then ZLO -> R1
    set_y(32'h4);
    dp_if.Rout[0] = 1; dp_if.ALU_opcode = OP_ADD; dp_if.Zin = 1;
    tick(); clear_ctl();
    check("add Z", dp_if.Z_register, 64'h13);
    dp_if.ZLOout = 1; dp_if.Rin[1] = 1;
    tick(); clear_ctl();
    check("R1 from ZLO", {32'd0, dp_if.R[1]}, 64'h13);

    // NOT of R5
    load_reg(5, 32'h12);
    dp_if.Rout[5] = 1; dp_if.ALU_opcode = OP_NOT; dp_if.Zin = 1;
    tick(); clear_ctl();
    check("not ZLO", {32'd0, dp_if.ZLO}, 64'hFFFF_FFED);
    check("not ZHI", {32'd0, dp_if.ZHI}, 64'd0);

    // Table of ALU vectors {op, A, B, Z}
    vecs.push_back('{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0000_0000_0001});
    vecs.push_back('{OP_SUB,  32'h0000_0003, 32'h0000_0005, 64'h0000_0000_FFFF_FFFE});
    vecs.push_back('{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 64'h0000_0000_00F0_1200});
    vecs.push_back('{OP_OR,   32'hF000_0001, 32'h0000_0F00, 64'h0000_0000_F000_0F01});
    vecs.push_back('{OP_SHR,  32'h8000_0000, 32'h0000_0021, 64'h0000_0000_4000_0000});
    vecs.push_back('{OP_SHRA, 32'h8000_0000, 32'h0000_0004, 64'h0000_0000_F800_0000});
    vecs.push_back('{OP_SHL,  32'hFFFF_FFFF, 32'h0000_001F, 64'h0000_0000_8000_0000});
    vecs.push_back('{OP_ROR,  32'h0000_0001, 32'h0000_0001, 64'h0000_0000_8000_0000});
    vecs.push_back('{OP_ROR,  32'h1234_5678, 32'h0000_0000, 64'h0000_0000_1234_5678});
    vecs.push_back('{OP_ROL,  32'h8000_0000, 32'h0000_0001, 64'h0000_0000_0000_0001});
    vecs.push_back('{OP_MUL,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA});
    vecs.push_back('{OP_DIV,  32'h0000_0011, 32'h0000_0005, 64'h0000_0002_0000_0003});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{OP_DIV,  32'h0000_0011, 32'h0000_0000, 64'h0000_0000_0000_0000});
    vecs.push_back('{OP_NEG,  32'h0000_0000, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{5'b01011, 32'h0000_0005, 32'h0000_0007, 64'h0000_0000_0000_0000});
    foreach (vecs[k]) begin
      run_alu(vecs[k].op, vecs[k].a, vecs[k].b);
      check($sformatf("vec%0d op%0d", k, vecs[k].op), dp_if.Z_register, vecs[k].z);
    end

    // DIV result split to HI/LO via ZHIout and the ZLowSelect alias
    run_alu(OP_DIV, 32'd17, 32'd5);
    dp_if.ZHIout = 1; dp_if.HIin = 1;
    tick(); clear_ctl();
    check("HI from ZHI", {32'd0, dp_if.HI}, 64'd2);
    dp_if.ZLowSelect = 1; dp_if.Loin = 1;
    tick(); clear_ctl();
    check("LO via ZLowSelect", {32'd0, dp_if.LO}, 64'd3);
    dp_if.ZHighSelect = 1; dp_if.Rin[6] = 1;
    tick(); clear_ctl();
    check("R6 via ZHighSelect", {32'd0, dp_if.R[6]}, 64'd2);

    // Bus priority
    load_reg(2, 32'h0000_AAAA);
    load_reg(7, 32'h0000_0077);
    mdr_load(32'h100);
    dp_if.MDRout = 1; dp_if.PCin = 1;
    tick(); clear_ctl();
    check("PC load", {32'd0, dp_if.PC}, 64'h100);
    dp_if.Rout[2] = 1; dp_if.PCout = 1; dp_if.Rin[9] = 1;
    tick(); clear_ctl();
    check("R2 over PC", {32'd0, dp_if.R[9]}, 64'hAAAA);
    dp_if.Rout[7] = 1; dp_if.Rout[2] = 1; dp_if.Rin[10] = 1;
    tick(); clear_ctl();
    check("lowest reg wins", {32'd0, dp_if.R[10]}, 64'hAAAA);
    dp_if.Rin[9] = 1;
    tick(); clear_ctl();
    check("idle bus is 0", {32'd0, dp_if.R[9]}, 64'd0);

    // C operand from IR
    mdr_load(32'h0007_FFFF);
    dp_if.MDRout = 1; dp_if.IRin = 1;
    tick(); clear_ctl();
    dp_if.Cout = 1; dp_if.Rin[11] = 1;
    tick(); clear_ctl();
    check("C sign ext neg", {32'd0, dp_if.R[11]}, 64'hFFFF_FFFF);
    mdr_load(32'hFFF3_0001);
    dp_if.MDRout = 1; dp_if.IRin = 1;
    tick(); clear_ctl();
    dp_if.Cout = 1; dp_if.Yout = 1; dp_if.Rin[11] = 1;
    tick(); clear_ctl();
    check("C pos over Y", {32'd0, dp_if.R[11]}, 64'h0003_0001);
    dp_if.InPortout = 1; dp_if.Cout = 1; dp_if.Rin[12] = 1;
    tick(); clear_ctl();
`ifdef DATAPATH_INPORT_EN
    check("InPort over C", {32'd0, dp_if.R[12]}, 64'h1234_5678);
`else
    check("InPort drives 0", {32'd0, dp_if.R[12]}, 64'd0);
`endif

    // PC: IncPC beats PCin
    mdr_load(32'h555);
    dp_if.MDRout = 1; dp_if.PCin = 1; dp_if.IncPC = 1;
    tick(); clear_ctl();
    check("IncPC over PCin", {32'd0, dp_if.PC}, 64'h101);

    // Z half loads and Zin priority
    mdr_load(32'hCAFE);
    dp_if.MDRout = 1; dp_if.ZHIin = 1; dp_if.ZLOin = 1;
    tick(); clear_ctl();
    check("ZHIin+ZLOin", dp_if.Z_register, 64'h0000_CAFE_0000_CAFE);
    set_y(32'h1);
    mdr_load(32'hCAFE);
    dp_if.MDRout = 1; dp_if.ALU_opcode = OP_ADD; dp_if.Zin = 1; dp_if.ZHIin = 1;
    tick(); clear_ctl();
    check("Zin over ZHIin", dp_if.Z_register, 64'h0000_0000_0000_CAFF);

    // MDR from bus, and no load without MDRin
    dp_if.Rout[1] = 1; dp_if.MDRin = 1; dp_if.MDRread = 0; dp_if.Mdatain = 32'hBAD0;
    tick(); clear_ctl();
    check("MDR from bus", {32'd0, dp_if.MDR}, 64'h13);
    dp_if.MDRread = 1; dp_if.Mdatain = 32'hBAD1;
    tick(); clear_ctl();
    check("MDR hold", {32'd0, dp_if.MDR}, 64'h13);
    dp_if.MDRout = 1; dp_if.MARin = 1;
    tick(); clear_ctl();
    check("MAR load", {32'd0, dp_if.MAR}, 64'h13);

    // Random ALU operations against the model
    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 17));
      ra  = $urandom;
      rb  = (n % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_alu(rop, ra, rb);
      check($sformatf("rand%0d op%0d a=%h b=%h", n, rop, ra, rb), dp_if.Z_register,
            model_alu(rop, ra, rb));
    end

    // Reset in the same cycle as Zin and R3in
    set_y(32'h4);
    mdr_load(32'hDEAD);
    dp_if.MDRout = 1; dp_if.ALU_opcode = OP_ADD; dp_if.Zin = 1; dp_if.Rin[3] = 1;
    clr = 0;
    tick(); clear_ctl();
    clr = 1;
    check("reset beats Zin", dp_if.Z_register, 64'd0);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("reset R%0d", i), {32'd0, dp_if.R[i]}, 64'd0);
    check("reset HI", {32'd0, dp_if.HI}, 64'd0);
    check("reset LO", {32'd0, dp_if.LO}, 64'd0);
    check("reset Y", {32'd0, dp_if.Y}, 64'd0);
    check("reset IR", {32'd0, dp_if.IR}, 64'd0);
    check("reset MAR", {32'd0, dp_if.MAR}, 64'd0);
    check("reset MDR2", {32'd0, dp_if.MDR}, 64'd0);
    check("reset PC2", {32'd0, dp_if.PC}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
